// File: rtl/avmm_resp_pkg.sv
// Shared widths, address helpers and read-pipe stage type
// for the avmm_0_rw memory responder.
package avmm_resp_pkg;

  localparam int AVMM_ADDR_W = 64;
  localparam int AVMM_DATA_W = 64;
  localparam int AVMM_BE_W   = AVMM_DATA_W / 8;
  localparam int AVMM_DEPTH  = 1024;
  localparam int AVMM_IDX_W  = $clog2(AVMM_DEPTH);
  localparam int AVMM_LSB    = $clog2(AVMM_BE_W);

  typedef struct packed {
    logic                   valid;
    logic [AVMM_DATA_W-1:0] data;
  } rd_stage_t;

  // Full 64-bit math so the offset never wraps.
  function automatic logic [63:0] word_index(
    input logic [63:0] addr,
    input logic [63:0] base,
    input int          lsb
  );
    return (addr - base) >> lsb;
  endfunction

  function automatic logic in_range(
    input logic [63:0] addr,
    input logic [63:0] base,
    input int          lsb,
    input logic [63:0] depth
  );
    return (addr >= base) &&
           (word_index(addr, base, lsb) < depth);
  endfunction

endpackage

// File: rtl/avmm_rw_responder_if.sv
// Avalon-MM avmm_0_rw bus bundle: master drives requests,
// slave returns fixed-latency readdata.
interface avmm_rw_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] avmm_0_rw_address;
  logic [BE_W-1:0]   avmm_0_rw_byteenable;
  logic              avmm_0_rw_read;
  logic              avmm_0_rw_write;
  logic [DATA_W-1:0] avmm_0_rw_writedata;
  logic [DATA_W-1:0] avmm_0_rw_readdata;

  modport master (
    output avmm_0_rw_address,
    output avmm_0_rw_byteenable,
    output avmm_0_rw_read,
    output avmm_0_rw_write,
    output avmm_0_rw_writedata,
    input  avmm_0_rw_readdata
  );

  modport slave (
    input  avmm_0_rw_address,
    input  avmm_0_rw_byteenable,
    input  avmm_0_rw_read,
    input  avmm_0_rw_write,
    input  avmm_0_rw_writedata,
    output avmm_0_rw_readdata
  );

endinterface

// File: rtl/avmm_resp_rdpipe.sv
// LAT-deep {valid,data} delay line; the last stage
// only reloads data on a valid beat so readdata holds.
module avmm_resp_rdpipe
  import avmm_resp_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic      clock,
  input  logic      reset,
  input  rd_stage_t i_stage,
  output rd_stage_t o_stage
);

  rd_stage_t r_pipe  [LAT];
  rd_stage_t w_chain [LAT+1];

  always_comb begin
    w_chain[0] = i_stage;
    for (int i = 0; i < LAT; i++)
      w_chain[i+1] = r_pipe[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++)
        r_pipe[i] <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        if (i == LAT-1) begin
          r_pipe[i].valid <= w_chain[i].valid;
          if (w_chain[i].valid)
            r_pipe[i].data <= w_chain[i].data;
        end else begin
          r_pipe[i] <= w_chain[i];
        end
      end
    end
  end

  assign o_stage = w_chain[LAT];

endmodule

// File: rtl/avmm_rw_responder.sv
// Avalon-MM memory responder with backdoor port and sticky
// error flags; AVMM_RESP_STATS_EN adds access counters.
module avmm_rw_responder
  import avmm_resp_pkg::*;
#(
  parameter int          ADDR_W       = AVMM_ADDR_W,
  parameter int          DATA_W       = AVMM_DATA_W,
  parameter int          DEPTH        = AVMM_DEPTH,
  parameter logic [63:0] BASE_ADDR    = 64'd0,
  parameter int          READ_LATENCY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  avmm_rw_responder_if.slave       s,
  output logic                     rd_valid,
  output logic                     err_oob,
  output logic                     err_rw,
  input  logic                     bd_en,
  input  logic                     bd_we,
  input  logic [$clog2(DEPTH)-1:0] bd_index,
  input  logic [DATA_W-1:0]        bd_wdata,
  output logic [DATA_W-1:0]        bd_rdata,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LSB   = $clog2(BE_W);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_bus;
  logic              w_in;
  logic [63:0]       w_addr;
  logic [IDX_W-1:0]  w_idx;
  logic              w_rd_ok;
  logic              w_wr_ok;
  rd_stage_t         w_req;
  rd_stage_t         w_resp;
  logic              r_err_oob;
  logic              r_err_rw;

  assign w_bus   = !bd_en;
  assign w_addr  = 64'(s.avmm_0_rw_address);
  assign w_in    = in_range(w_addr, BASE_ADDR,
                            LSB, 64'(DEPTH));
  assign w_idx   = IDX_W'(word_index(w_addr,
                                     BASE_ADDR, LSB));
  assign w_rd_ok = s.avmm_0_rw_read && w_bus;
  assign w_wr_ok = s.avmm_0_rw_write && w_bus;

  always_ff @(posedge clock) begin
    if (bd_en && bd_we) begin
      r_mem[bd_index] <= bd_wdata;
    end else if (w_wr_ok && w_in) begin
      for (int k = 0; k < BE_W; k++)
        if (s.avmm_0_rw_byteenable[k])
          r_mem[w_idx][8*k +: 8] <=
            s.avmm_0_rw_writedata[8*k +: 8];
    end
  end

  assign bd_rdata = r_mem[bd_index];

  // Blocked or out-of-range reads still answer, with zero.
  always_comb begin
    w_req       = '0;
    w_req.valid = s.avmm_0_rw_read;
    if (w_rd_ok && w_in)
      w_req.data = r_mem[w_idx];
  end

  avmm_resp_rdpipe #(
    .LAT (READ_LATENCY)
  ) u_rdpipe (
    .clock   (clock),
    .reset   (reset),
    .i_stage (w_req),
    .o_stage (w_resp)
  );

  assign s.avmm_0_rw_readdata = w_resp.data;
  assign rd_valid             = w_resp.valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_oob <= 1'b0;
      r_err_rw  <= 1'b0;
    end else if (w_bus) begin
      if (s.avmm_0_rw_read && s.avmm_0_rw_write)
        r_err_rw <= 1'b1;
      if ((s.avmm_0_rw_read || s.avmm_0_rw_write)
          && !w_in)
        r_err_oob <= 1'b1;
    end
  end

  assign err_oob = r_err_oob;
  assign err_rw  = r_err_rw;

`ifdef AVMM_RESP_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_ok && r_rd_cnt != '1)
        r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_wr_ok && r_wr_cnt != '1)
        r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule
